// File: rtl/seg_stream_pkg.sv
`default_nettype none
// ============================================================================
// seg_stream_pkg - shared types and constants for the seven-segment scan rx
// Rev 1.0
// ============================================================================
package seg_stream_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 6;
  localparam int NUM_SEGS   = 7;

  localparam logic [3:0] BCD_BLANK = 4'd10;
  localparam logic [3:0] BCD_BAD   = 4'd15;

  // Active-low patterns, bit i drives segment i (bit 6 = segment g)
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage
`default_nettype wire

// File: rtl/seg7_to_bcd.sv
`default_nettype none
// ============================================================================
// seg7_to_bcd - combinational seven-segment pattern to BCD decoder
// Rev 1.0
// ============================================================================
module seg7_to_bcd
  import seg_stream_pkg::*;
(
  input  logic [6:0] pattern,
  input  logic       polarity,
  output logic [3:0] bcd,
  output logic       err
);

  logic [6:0] norm;

  always_comb begin
    norm = polarity ? pattern : ~pattern;
    bcd  = BCD_BAD;
    err  = 1'b0;
    case (norm)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: bcd = BCD_BLANK;
      default:   err = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_stream_rx.sv
`default_nettype none
// ============================================================================
// seg_stream_rx - rebuilds a 6-digit snapshot from a serial seven-segment scan
// Rev 1.0
// ============================================================================
module seg_stream_rx
  import seg_stream_pkg::*;
#(
  parameter int STABLE_CYC  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seg_bit,
  input  logic [2:0]  seg_sel,
  input  logic [2:0]  disp_sel,
  input  logic        disp_type,
  output logic [23:0] digits,
  output logic [5:0]  digit_err,
  output logic        frame_stb,
  output logic        sync_err,
  output logic        locked
);

  localparam int               CNT_W   = $clog2(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

  // Newest sample enters at index 0; the oldest stage feeds the logic
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic                        bit_s;
  logic                        type_s;
  logic [2:0]                  seg_s;
  logic [2:0]                  disp_s;
  logic [5:0]                  addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], {disp_type, disp_sel, seg_sel, seg_bit}};
  end

  assign {type_s, disp_s, seg_s, bit_s} = sync_q[SYNC_STAGES-1];
  assign addr = {disp_s, seg_s};

  logic [5:0]       prev_addr;
  logic [CNT_W-1:0] cnt;
  logic             captured;
  logic             capture;

  // Gated on an unchanged address so a slot change never inherits the old count
  assign capture = (addr == prev_addr) && (cnt == CNT_MAX) && !captured;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_addr <= '0;
      cnt       <= '0;
      captured  <= 1'b0;
    end else begin
      prev_addr <= addr;
      if (addr != prev_addr) begin
        cnt      <= '0;
        captured <= 1'b0;
      end else begin
        if (cnt < CNT_MAX) cnt <= cnt + CNT_W'(1);
        if (capture)       captured <= 1'b1;
      end
    end
  end

  state_t                              state;
  logic [2:0]                          exp_disp;
  logic [2:0]                          exp_seg;
  logic [NUM_DIGITS-1:0][NUM_SEGS-1:0] shadow;
  logic [23:0]                         dec_bcd;
  logic [5:0]                          dec_err;
  logic                                at_exp;
  logic                                at_origin;
  logic                                last_slot;

  assign at_exp    = (disp_s == exp_disp) && (seg_s == exp_seg);
  assign at_origin = (addr == 6'd0);
  assign last_slot = (exp_disp == 3'(NUM_DIGITS - 1)) && (exp_seg == 3'(NUM_SEGS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      exp_disp  <= '0;
      exp_seg   <= '0;
      shadow    <= '0;
      digits    <= '0;
      digit_err <= '0;
      frame_stb <= 1'b0;
      sync_err  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      frame_stb <= 1'b0;
      sync_err  <= 1'b0;
      case (state)
        HUNT: begin
          if (capture && at_origin) begin
            shadow[0][0] <= bit_s;
            exp_disp     <= 3'd0;
            exp_seg      <= 3'd1;
            state        <= FILL;
          end
        end
        FILL: begin
          if (capture) begin
            if (at_exp) begin
              shadow[exp_disp][exp_seg] <= bit_s;
              if (last_slot) begin
                state <= COMMIT;
              end else if (exp_seg == 3'(NUM_SEGS - 1)) begin
                exp_seg  <= 3'd0;
                exp_disp <= exp_disp + 3'd1;
              end else begin
                exp_seg <= exp_seg + 3'd1;
              end
            end else begin
              sync_err <= 1'b1;
              locked   <= 1'b0;
              if (at_origin) begin
                shadow[0][0] <= bit_s;
                exp_disp     <= 3'd0;
                exp_seg      <= 3'd1;
              end else begin
                state <= HUNT;
              end
            end
          end
        end
        COMMIT: begin
          digits    <= dec_bcd;
          digit_err <= dec_err;
          frame_stb <= 1'b1;
          locked    <= 1'b1;
          state     <= HUNT;
        end
        default: state <= HUNT;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    seg7_to_bcd u_dec (
      .pattern  (shadow[i]),
      .polarity (type_s),
      .bcd      (dec_bcd[i*4 +: 4]),
      .err      (dec_err[i])
    );
  end

endmodule
`default_nettype wire

// File: doc/seg_stream_rx.md
Name: seg_stream_rx

Overview:
- Display-side receiver for the serialized seven-segment scan stream the clock core drives:
  - `segments_` carries one segment bit.
  - `segment_select_` carries the segment index (0..6).
  - `disp_select_` carries the digit index (0..5).
- The block samples the slow scan stream in the `clk` domain and rebuilds the six 7-bit digit patterns per frame.
- It decodes each pattern back to BCD, flags malformed patterns and scan-order breaks, and presents a frame-coherent 6-digit snapshot to downstream logic or a test monitor.

Parameters:
- STABLE_CYC, 4, number of consecutive `clk` cycles an address must be stable before its bit is captured (min 2)
- SYNC_STAGES, 2, flip-flop stages in the input synchronizers (min 2)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- seg_bit  input  1  serialized segment value (`segments_` of the transmitter)
- seg_sel  input  3  segment index of current bit
- disp_sel  input  3  digit index of current bit
- disp_type  input  1  polarity: 1 = raw stream is active-low patterns, 0 = inverted (active-high)
- digits  output  24  six BCD digits; [3:0] = digit 0 (units seconds) … [23:20] = digit 5; 10 = blank, 15 = undecodable
- digit_err  output  6  bit i set when digit i pattern matched no table entry
- frame_stb  output  1  one-cycle pulse when `digits` and `digit_err` update
- sync_err  output  1  one-cycle pulse on scan-order violation
- locked  output  1  high after a complete in-order frame; cleared on `sync_err`

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-low.
- Reset values: `digits`=0, `digit_err`=0, `frame_stb`=0, `sync_err`=0, `locked`=0, FSM=HUNT, shadow buffer=0, stable counter=0, captured flag=0.
- Synchronizers:
  - `seg_bit`, `seg_sel`, `disp_sel` and `disp_type` each pass through SYNC_STAGES flops.
  - All logic below uses the synchronized values.
- Address stability:
  - addr = {disp_sel, seg_sel}.
  - If addr differs from the previous cycle: cnt←0, captured←0.
  - Else if cnt < STABLE_CYC-1: cnt←cnt+1.
  - When cnt == STABLE_CYC-1 and captured == 0: raise a capture event for that cycle and set captured←1.
  - Exactly one capture per stable slot. A slot shorter than STABLE_CYC cycles is never captured.
- FSM states:
  - HUNT:
    - Capture with addr=(0,0): write shadow[0][0], set exp←(0,1), go to FILL.
    - Other captures are ignored silently.
  - FILL, on capture with addr == exp:
    - Write shadow[disp][seg] = bit.
    - Advance exp: seg 6 → seg 0 of disp+1.
    - If exp was (5,6), go to COMMIT.
  - FILL, on capture with addr != exp:
    - Pulse `sync_err` and set `locked`←0.
    - If addr=(0,0): restart the frame as in HUNT, staying in FILL.
    - Otherwise go to HUNT.
    - Illegal addresses (seg_sel=7 or disp_sel≥6) always mismatch.
  - COMMIT (one cycle):
    - Decode all six shadow patterns and register `digits` and `digit_err`.
    - Pulse `frame_stb` and set `locked`←1, then return to HUNT.
    - `frame_stb` is therefore asserted exactly 1 cycle after the capture of (5,6).
- Decode:
  - norm = disp_type ? raw : ~raw, using the synchronized `disp_type` sampled in COMMIT.
  - norm is matched against the active-low table (bit i = segment i):
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, blank=1111111→10
  - No match → nibble 15 and digit_err[i]=1.
- A partial frame never alters `digits`; previous outputs hold until the next commit.
- Reset mid-frame discards the shadow contents and returns to HUNT.

Decomposition:
- Package `seg_stream_pkg`:
  - FSM state enum {HUNT, FILL, COMMIT}
  - 7-bit pattern constants SEG_0..SEG_9, SEG_BLANK
  - NUM_DIGITS=6, NUM_SEGS=7, BCD_BLANK=10, BCD_BAD=15
- One sub-module `seg7_to_bcd`:
  - Inputs: pattern[6:0], polarity.
  - Outputs: bcd[3:0], err.
  - Purely combinational, instantiated six times in COMMIT.

Test Plan:
- Reset low mid-stream → all outputs 0, `locked`=0; after release, a full in-order frame encoding 12:34:56 with disp_type=1 → `frame_stb` once, `digits`=24'h123456, `digit_err`=0, `locked`=1.
- Same time values sent with disp_type=0 and inverted bits → identical `digits`=24'h123456.
- Frame with digit 2 pattern 1111111 and digit 3 pattern 0101010 → nibble[11:8]=10, nibble[15:12]=15, `digit_err`=6'b001000.
- Skip slot (2,3) mid-frame → `sync_err` pulses once, `locked`=0, no `frame_stb`, `digits` unchanged; the next full frame relocks.
- Slot (1,4) held only STABLE_CYC-1 cycles → not captured; the next slot (1,5) is a mismatch → `sync_err`.
- Back-to-back frames with one digit changing → `frame_stb` spacing equals 42 slots, and `digits` updates only at the strobe.
